// File: rtl/regfile_scoreboard.sv
// Architectural register file x0-x31 with per-register in-flight write counters and a same-cycle writeback bypass.
// Latency: reads are combinational; a write reaches regs one edge later; an issue marks busy_o[rd] after its edge.
// Backpressure: iss_ready_o drops while a used source has an outstanding write, or rd's counter is saturated.
//
// Ports:
//   clk, rst (async, active-low)
//   rdvalid_i/rdnum_i/rddata_i : writeback commit of one register
//   iss_*                      : issuing instruction (sources, uses, destination) and its ready
//   r0data_o/r1data_o          : rs1/rs2 operands, bypassed from the writeback
//   busy_o                     : per-register "pending write" flags
//   underflow_o                : sticky flag for a writeback to an untracked register
module regfile_scoreboard #(
    parameter int PEND_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdvalid_i,
    input  logic [4:0]  rdnum_i,
    input  logic [31:0] rddata_i,
    input  logic        iss_valid_i,
    output logic        iss_ready_o,
    input  logic [4:0]  iss_rs1_i,
    input  logic [4:0]  iss_rs2_i,
    input  logic        iss_rs1use_i,
    input  logic        iss_rs2use_i,
    input  logic        iss_rdwen_i,
    input  logic [4:0]  iss_rd_i,
    output logic [31:0] r0data_o,
    output logic [31:0] r1data_o,
    output logic [31:0] busy_o,
    output logic        underflow_o
);

    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;

    // Entry 0 of both arrays is cleared by reset and never written,
    // so indexing with a register number of 0 is always harmless.
    logic [31:0]       regs [0:31];
    logic [PEND_W-1:0] pend [0:31];

    logic wb_hit;
    logic haz_rs1;
    logic haz_rs2;
    logic dst_stall;
    logic fire;

    // x0 writebacks do nothing at all: no data, no counter, no underflow.
    assign wb_hit = rdvalid_i && (rdnum_i != 5'd0);

    // Operand read: x0 is zero, then the in-flight writeback, then the array.
    always_comb begin
        r0data_o = regs[iss_rs1_i];
        if (iss_rs1_i == 5'd0) begin
            r0data_o = 32'd0;
        end else if (wb_hit && (rdnum_i == iss_rs1_i)) begin
            r0data_o = rddata_i;
        end
    end

    always_comb begin
        r1data_o = regs[iss_rs2_i];
        if (iss_rs2_i == 5'd0) begin
            r1data_o = 32'd0;
        end else if (wb_hit && (rdnum_i == iss_rs2_i)) begin
            r1data_o = rddata_i;
        end
    end

    // A source is clear when its last outstanding write lands this cycle;
    // the bypass above then supplies the value.
    always_comb begin
        haz_rs1 = iss_rs1use_i && (iss_rs1_i != 5'd0) && (pend[iss_rs1_i] != PEND_ZERO)
                  && !(wb_hit && (rdnum_i == iss_rs1_i) && (pend[iss_rs1_i] == PEND_ONE));
        haz_rs2 = iss_rs2use_i && (iss_rs2_i != 5'd0) && (pend[iss_rs2_i] != PEND_ZERO)
                  && !(wb_hit && (rdnum_i == iss_rs2_i) && (pend[iss_rs2_i] == PEND_ONE));
        // A saturated counter can take one more issue if a writeback frees a slot now.
        dst_stall = iss_rdwen_i && (iss_rd_i != 5'd0) && (pend[iss_rd_i] == PEND_MAX)
                    && !(wb_hit && (rdnum_i == iss_rd_i));
    end

    // No dependence on iss_valid_i: ready is purely a function of the request.
    assign iss_ready_o = !(haz_rs1 || haz_rs2 || dst_stall);
    assign fire        = iss_valid_i && iss_ready_o;

    always_comb begin
        busy_o = 32'd0;
        for (int n = 1; n < 32; n++) begin
            busy_o[n] = (pend[n] != PEND_ZERO);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 32; n++) begin
                regs[n] <= 32'd0;
                pend[n] <= PEND_ZERO;
            end
            underflow_o <= 1'b0;
        end else begin
            for (int n = 1; n < 32; n++) begin
                logic inc;
                logic dec;
                inc = fire && iss_rdwen_i && (iss_rd_i == 5'(n));
                dec = wb_hit && (rdnum_i == 5'(n));
                if (dec) begin
                    regs[n] <= rddata_i;
                end
                if (inc && !dec) begin
                    pend[n] <= pend[n] + PEND_ONE;
                end else if (dec && !inc) begin
                    // Writeback with nothing tracked: keep the counter at zero and flag it.
                    if (pend[n] == PEND_ZERO) begin
                        underflow_o <= 1'b1;
                    end else begin
                        pend[n] <= pend[n] - PEND_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: linear steps, hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are sampled 3 ns later.
// Counter width is the default (2), so at most 3 writes per register are in flight.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        rdvalid_i;
    logic [4:0]  rdnum_i;
    logic [31:0] rddata_i;
    logic        iss_valid_i;
    logic        iss_ready_o;
    logic [4:0]  iss_rs1_i;
    logic [4:0]  iss_rs2_i;
    logic        iss_rs1use_i;
    logic        iss_rs2use_i;
    logic        iss_rdwen_i;
    logic [4:0]  iss_rd_i;
    logic [31:0] r0data_o;
    logic [31:0] r1data_o;
    logic [31:0] busy_o;
    logic        underflow_o;

    int total;
    int bad;

    regfile_scoreboard #(.PEND_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdvalid_i    (rdvalid_i),
        .rdnum_i      (rdnum_i),
        .rddata_i     (rddata_i),
        .iss_valid_i  (iss_valid_i),
        .iss_ready_o  (iss_ready_o),
        .iss_rs1_i    (iss_rs1_i),
        .iss_rs2_i    (iss_rs2_i),
        .iss_rs1use_i (iss_rs1use_i),
        .iss_rs2use_i (iss_rs2use_i),
        .iss_rdwen_i  (iss_rdwen_i),
        .iss_rd_i     (iss_rd_i),
        .r0data_o     (r0data_o),
        .r1data_o     (r1data_o),
        .busy_o       (busy_o),
        .underflow_o  (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; the caller then drives new inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling (still before the falling edge).
    task automatic settle();
        #3;
    endtask

    task automatic idle();
        rdvalid_i    = 1'b0;
        rdnum_i      = 5'd0;
        rddata_i     = 32'd0;
        iss_valid_i  = 1'b0;
        iss_rs1_i    = 5'd0;
        iss_rs2_i    = 5'd0;
        iss_rs1use_i = 1'b0;
        iss_rs2use_i = 1'b0;
        iss_rdwen_i  = 1'b0;
        iss_rd_i     = 5'd0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle();

        // ---- during reset ----
        #12;
        chk("rst_ready", 32'(iss_ready_o), 32'd1);
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_underflow", 32'(underflow_o), 32'd0);
        #10 rst = 1'b1;

        // ---- reset then read ----
        tick();
        iss_rs1_i = 5'd5; iss_rs2_i = 5'd0; iss_rs1use_i = 1'b1; iss_rs2use_i = 1'b1;
        settle();
        chk("read_r0_after_rst", r0data_o, 32'd0);
        chk("read_r1_after_rst", r1data_o, 32'd0);
        chk("read_ready_after_rst", 32'(iss_ready_o), 32'd1);
        chk("read_busy_after_rst", busy_o, 32'd0);

        // ---- basic RAW on x3 ----
        tick(); idle();
        iss_valid_i = 1'b1; iss_rdwen_i = 1'b1; iss_rd_i = 5'd3;
        settle();
        chk("raw_issue_ready", 32'(iss_ready_o), 32'd1);
        tick(); idle();
        iss_valid_i = 1'b1; iss_rs1_i = 5'd3; iss_rs1use_i = 1'b0;
        settle();
        chk("raw_busy3", busy_o, 32'h0000_0008);
        chk("raw_unused_src_ready", 32'(iss_ready_o), 32'd1);
        iss_valid_i = 1'b0; iss_rs1use_i = 1'b1;
        #1;
        chk("raw_stall", 32'(iss_ready_o), 32'd0);
        tick();
        iss_valid_i = 1'b1;
        settle();
        chk("raw_still_stalled", 32'(iss_ready_o), 32'd0);
        rdvalid_i = 1'b1; rdnum_i = 5'd3; rddata_i = 32'hDEAD_BEEF;
        #1;
        chk("raw_wb_ready", 32'(iss_ready_o), 32'd1);
        chk("raw_wb_bypass", r0data_o, 32'hDEAD_BEEF);
        tick(); idle();
        iss_rs1_i = 5'd3;
        settle();
        chk("raw_busy_clear", busy_o, 32'd0);
        chk("raw_regs3", r0data_o, 32'hDEAD_BEEF);

        // ---- three writes in flight to x7, fourth stalls ----
        idle();
        iss_valid_i = 1'b1; iss_rdwen_i = 1'b1; iss_rd_i = 5'd7;
        tick(); tick(); tick();
        settle();
        chk("multi_busy7", busy_o, 32'h0000_0080);
        chk("multi_fourth_stall", 32'(iss_ready_o), 32'd0);
        rdvalid_i = 1'b1; rdnum_i = 5'd7; rddata_i = 32'h0000_0070;
        #1;
        chk("multi_fourth_accept", 32'(iss_ready_o), 32'd1);
        tick();
        iss_valid_i = 1'b0; iss_rdwen_i = 1'b0;
        settle();
        chk("multi_busy_after_swap", busy_o, 32'h0000_0080);
        // Counter is still 3 (inc and dec cancelled): a new rdwen to x7 must stall.
        iss_rdwen_i = 1'b1; rdvalid_i = 1'b0;
        #1;
        chk("multi_pend_still_max", 32'(iss_ready_o), 32'd0);
        iss_rdwen_i = 1'b0; rdvalid_i = 1'b1;
        tick();
        settle();
        chk("drain1_busy", busy_o, 32'h0000_0080);
        tick();
        settle();
        chk("drain2_busy", busy_o, 32'h0000_0080);
        tick();
        rdvalid_i = 1'b0;
        settle();
        chk("drain3_busy", busy_o, 32'd0);
        chk("drain_no_underflow", 32'(underflow_o), 32'd0);

        // ---- simultaneous inc/dec on x9 ----
        idle();
        iss_valid_i = 1'b1; iss_rdwen_i = 1'b1; iss_rd_i = 5'd9;
        tick();
        rdvalid_i = 1'b1; rdnum_i = 5'd9; rddata_i = 32'h0000_0011;
        settle();
        chk("sim_ready", 32'(iss_ready_o), 32'd1);
        tick(); idle();
        iss_rs1_i = 5'd9; iss_rs1use_i = 1'b1; iss_rs2_i = 5'd7;
        settle();
        chk("sim_busy9", busy_o, 32'h0000_0200);
        chk("sim_regs9", r0data_o, 32'h0000_0011);
        chk("sim_src_stall", 32'(iss_ready_o), 32'd0);
        chk("rs2_reads_regs7", r1data_o, 32'h0000_0070);
        rdvalid_i = 1'b1; rdnum_i = 5'd9; rddata_i = 32'h0000_0022;
        tick(); idle();
        settle();
        chk("sim_drained", busy_o, 32'd0);

        // ---- rs2 hazard and bypass on x12 ----
        iss_valid_i = 1'b1; iss_rdwen_i = 1'b1; iss_rd_i = 5'd12;
        tick(); idle();
        iss_valid_i = 1'b1; iss_rs2_i = 5'd12; iss_rs2use_i = 1'b1;
        settle();
        chk("rs2_stall", 32'(iss_ready_o), 32'd0);
        rdvalid_i = 1'b1; rdnum_i = 5'd12; rddata_i = 32'h0000_C0C0;
        #1;
        chk("rs2_wb_ready", 32'(iss_ready_o), 32'd1);
        chk("rs2_bypass", r1data_o, 32'h0000_C0C0);

        // ---- x0 handling ----
        tick(); idle();
        iss_valid_i = 1'b1; iss_rdwen_i = 1'b1; iss_rd_i = 5'd0;
        rdvalid_i = 1'b1; rdnum_i = 5'd0; rddata_i = 32'hFFFF_FFFF;
        iss_rs1_i = 5'd0; iss_rs1use_i = 1'b1;
        settle();
        chk("x0_ready", 32'(iss_ready_o), 32'd1);
        chk("x0_no_bypass", r0data_o, 32'd0);
        tick(); idle();
        settle();
        chk("x0_busy", busy_o, 32'd0);
        chk("x0_no_underflow", 32'(underflow_o), 32'd0);
        chk("x0_read_zero", r0data_o, 32'd0);

        // ---- underflow, then asynchronous reset ----
        rdvalid_i = 1'b1; rdnum_i = 5'd4; rddata_i = 32'h0000_0044;
        settle();
        chk("uf_before_edge", 32'(underflow_o), 32'd0);
        tick(); idle();
        iss_valid_i = 1'b1; iss_rdwen_i = 1'b1; iss_rd_i = 5'd5;
        settle();
        chk("uf_set", 32'(underflow_o), 32'd1);
        tick(); idle();
        iss_rs1_i = 5'd4;
        settle();
        chk("uf_regs4", r0data_o, 32'h0000_0044);
        chk("uf_busy5", busy_o, 32'h0000_0020);
        rst = 1'b0;
        #1;
        chk("arst_underflow", 32'(underflow_o), 32'd0);
        chk("arst_busy", busy_o, 32'd0);
        chk("arst_regs4", r0data_o, 32'd0);
        #4 rst = 1'b1;

        // Writeback of x5 after release: its tracking was discarded, so it underflows.
        tick();
        rdvalid_i = 1'b1; rdnum_i = 5'd5; rddata_i = 32'h0000_0055;
        tick(); idle();
        settle();
        chk("post_rst_underflow", 32'(underflow_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural register file (x0–x31) with in-flight write tracking. Sits between decode/issue and writeback. Accepts the writeback stage's rd write (valid/number/data), serves two source-operand reads to the issuing instruction with same-cycle write bypass, and holds issue off while a source register still has an outstanding write. x0 reads as zero, is never written and is never tracked.

## Interface

Parameters:
- `PEND_W`, default 2: width of each per-register pending-write counter. Maximum in-flight writes per register is 2^PEND_W−1.

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset; low clears all state immediately
- `rdvalid_i`  in  1  writeback commits a register write this cycle
- `rdnum_i`  in  5  writeback destination register
- `rddata_i`  in  32  writeback data
- `iss_valid_i`  in  1  issue stage presents an instruction
- `iss_ready_o`  out  1  instruction may issue this cycle; fire = `iss_valid_i & iss_ready_o`
- `iss_rs1_i`  in  5  source 1 register number
- `iss_rs2_i`  in  5  source 2 register number
- `iss_rs1use_i`  in  1  instruction reads rs1
- `iss_rs2use_i`  in  1  instruction reads rs2
- `iss_rdwen_i`  in  1  instruction will write rd
- `iss_rd_i`  in  5  destination register number
- `r0data_o`  out  32  rs1 operand, combinational
- `r1data_o`  out  32  rs2 operand, combinational
- `busy_o`  out  32  bit n set when pend[n] != 0; bit 0 always 0
- `underflow_o`  out  1  sticky; set when a writeback hits a register with pend = 0

## Operation

- State: `regs[1..31]` (32 bits each), `pend[1..31]` (PEND_W bits each), and `underflow_o`.
- Write: when `rdvalid_i & rdnum_i != 0`, `regs[rdnum_i] <= rddata_i` at the clock edge. Writes to x0 are dropped, and x0 is excluded from `underflow_o`.
- Read, per port (rs1 shown; rs2 works the same way):
  - x0 returns 0.
  - Otherwise, if `rdvalid_i & rdnum_i == rs1`, return `rddata_i` (bypass).
  - Otherwise return `regs[rs1]`.
  - Outputs are valid regardless of `iss_valid_i`.
- Source hazard on rs1: `iss_rs1use_i & rs1 != 0 & pend[rs1] != 0`, unless the current writeback targets rs1 and `pend[rs1] == 1`. In that exception the last outstanding write resolves now and its data is bypassed. rs2 uses the same rule.
- Destination stall: `iss_rdwen_i & iss_rd_i != 0 & pend[iss_rd_i] == max`, unless writeback to `iss_rd_i` occurs this cycle.
- `iss_ready_o` is the negation of the OR of both source hazards and the destination stall. It is combinational and does not depend on `iss_valid_i`.
- Counter update per register n ≠ 0:
  - inc = fire & `iss_rdwen_i` & `iss_rd_i == n`
  - dec = `rdvalid_i` & `rdnum_i == n`
  - inc only: +1. dec only: −1. Both: unchanged. Neither: hold.
  - dec when `pend[n] == 0` (and no inc): counter stays 0 and `underflow_o <= 1`. `underflow_o` is cleared only by reset.
- An instruction whose rd equals its rs may issue once the source hazard clears. The new pend increment does not affect its own read.

## Timing

- Reset (`rst` low, asynchronous): all `regs` = 0, all `pend` = 0, `underflow_o` = 0, `busy_o` = 0. Therefore `iss_ready_o` = 1 and `r0data_o`/`r1data_o` = 0 during and after reset.
- Reset asserted mid-operation discards all pending state. Writebacks that arrive after release increment `underflow_o`'s cause, and sets it, if their register is not re-tracked.
- Write latency: the value is visible through the bypass in the same cycle and from `regs` on the following cycle.
- Scoreboard latency: issue at edge k sets `busy_o[rd]` after edge k. A same-cycle dependent instruction cannot exist, because there is one issue per cycle.
- Issue is not registered. An instruction held with `iss_valid_i` high and `iss_ready_o` low must keep its inputs stable. The block needs no internal state for the stall.
- All `pend` changes happen only at rising edges of `clk`. There is no combinational path from `iss_valid_i` to `iss_ready_o`.

## Test plan

- Reset then read: release `rst`, read rs1=5, rs2=0 → `r0data_o`=0, `r1data_o`=0, `iss_ready_o`=1, `busy_o`=0.
- Basic RAW: issue rd=3 (rdwen) → `busy_o[3]`=1. Next cycle, present rs1=3 → `iss_ready_o`=0. Writeback x3=0xDEADBEEF → same cycle `iss_ready_o`=1 and `r0data_o`=0xDEADBEEF. Next cycle `busy_o[3]`=0.
- Multiple in flight: issue rd=7 three times → pend[7]=3, and a fourth rdwen to rd=7 stalls. First writeback → the fourth issue is accepted in that cycle and pend stays 3. Drain three writebacks → `busy_o[7]`=0 only after the third.
- Simultaneous inc/dec: issue rd=9 in the same cycle as writeback x9=0x11 with pend[9]=1 → pend[9] stays 1, `busy_o[9]`=1, `regs[9]`=0x11.
- x0 handling: issue rd=0 and writeback x0=0xFFFFFFFF → `busy_o`=0, a read of x0 returns 0, `underflow_o`=0, `iss_ready_o`=1.
- Underflow and async reset: writeback x4 with pend[4]=0 → `underflow_o`=1 after the edge. Pull `rst` low mid-cycle → `underflow_o`, `busy_o` and `regs` clear immediately, without waiting for a clock edge.
